// File: rtl/param_divider.sv
// param_divider: restoring shift-subtract divider producing one quotient bit per clock.
// Signed two's-complement division is compiled in only when PARAM_DIVIDER_SIGNED_EN is defined.
module param_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);
    state_t state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic dbz_q, dbz_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic sa_c, sb_c, fit_c;
    logic [WIDTH:0] part_c;
    logic [WIDTH-1:0] dvd_abs_c, dvs_abs_c, quo_mag_c, rmd_mag_c, quo_fin_c, rmd_fin_c;
`ifdef PARAM_DIVIDER_SIGNED_EN
    assign sa_c = sign_mode & Dividend[WIDTH-1];
    assign sb_c = sign_mode & Divisor[WIDTH-1];
`else
    logic unused_sign;
    assign unused_sign = sign_mode;
    assign sa_c = 1'b0;
    assign sb_c = 1'b0;
`endif
    assign dvd_abs_c = sa_c ? -Dividend : Dividend;
    assign dvs_abs_c = sb_c ? -Divisor : Divisor;
    // partial remainder is one bit wider than the operands so the shifted-in MSB is never lost
    assign part_c    = {rem_q, dvd_q[WIDTH-1]};
    assign fit_c     = part_c >= {1'b0, dvs_q};
    assign quo_mag_c = {dvd_q[WIDTH-2:0], fit_c};
    assign rmd_mag_c = fit_c ? WIDTH'(part_c - {1'b0, dvs_q}) : part_c[WIDTH-1:0];
    assign quo_fin_c = neg_quo_q ? -quo_mag_c : quo_mag_c;
    assign rmd_fin_c = neg_rem_q ? -rmd_mag_c : rmd_mag_c;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == IDLE && run) begin
            neg_quo_d = sa_c ^ sb_c;
            neg_rem_d = sa_c;
            dbz_d     = 1'b0;
            if (Divisor == '0) begin
                state_d = DONE;
                quo_d   = '1;
                rmd_d   = Dividend;
                dbz_d   = 1'b1;
            end else begin
                state_d = CALC;
                cnt_d   = '0;
                dvd_d   = dvd_abs_c;
                dvs_d   = dvs_abs_c;
                rem_d   = '0;
            end
        end else if (state_q == CALC) begin
            dvd_d = quo_mag_c;
            rem_d = rmd_mag_c;
            cnt_d = cnt_q + WIDTH'(1);
            if (cnt_q == LAST) begin
                state_d = DONE;
                cnt_d   = '0;
                quo_d   = quo_fin_c;
                rmd_d   = rmd_fin_c;
            end
        end else if (state_q == DONE && !run) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dbz_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
    assign Quotient    = quo_q;
    assign Remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign ready       = state_q == DONE;
    assign busy        = state_q == CALC;
endmodule

// File: tb/tb_param_divider.sv
// tb_param_divider: scoreboard bench for param_divider at WIDTH=32 and WIDTH=8.
// Signed cases are exercised only when PARAM_DIVIDER_SIGNED_EN is defined.
module tb_param_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, run = 1'b0, sign_mode = 1'b0;
    logic [31:0] Dividend = '0, Divisor = '0, Quotient, Remainder;
    logic ready, busy, div_by_zero;
    logic run8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, q8, r8;
    logic rdy8, busy8, dbz8;
    int n_checks = 0, n_errors = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    param_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .run(run), .sign_mode(sign_mode),
        .Dividend(Dividend), .Divisor(Divisor), .Quotient(Quotient), .Remainder(Remainder),
        .ready(ready), .busy(busy), .div_by_zero(div_by_zero)
    );
    param_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .run(run8), .sign_mode(1'b0),
        .Dividend(a8), .Divisor(b8), .Quotient(q8), .Remainder(r8),
        .ready(rdy8), .busy(busy8), .div_by_zero(dbz8)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic sm, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic s;
        s = sm;
`ifndef PARAM_DIVIDER_SIGNED_EN
        s = 1'b0;
`endif
        e.z   = (b == 0);
        e.lat = (b == 0) ? 1 : 33;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'h0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction
    task automatic run_op(input string tag, input logic sm, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int n;
        @(negedge clk);
        sign_mode = sm;
        Dividend  = a;
        Divisor   = b;
        run       = 1'b1;
        sb.push_back(model(sm, a, b));
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1 && b != 0) begin
                check({tag, "_busy"}, busy, 1);
                check({tag, "_dbz_clr"}, div_by_zero, 0);
            end
            // operands move during the operation; the latched copies must be used
            Dividend  = $urandom;
            Divisor   = $urandom;
            sign_mode = 1'($urandom_range(0, 1));
        end while (!ready && n < 100);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_q"}, Quotient, e.q);
        check({tag, "_r"}, Remainder, e.r);
        check({tag, "_dbz"}, div_by_zero, e.z);
        repeat (3) @(negedge clk);
        check({tag, "_hold_rdy"}, {ready, busy}, 2'b10);
        check({tag, "_hold_q"}, Quotient, e.q);
        run = 1'b0;
        @(negedge clk);
        check({tag, "_idle_rdy"}, {ready, busy}, 2'b00);
        check({tag, "_idle_r"}, Remainder, e.r);
    endtask
    initial begin
        exp_t e;
        int n;
        #1;
        check("rst_out", {Quotient, Remainder}, 64'h0);
        check("rst_flags", {ready, busy, div_by_zero}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("dbz", 1'b0, 32'h1234_5678, 32'h0);
        // abort an operation partway through CALC with an asynchronous reset
        @(negedge clk);
        Dividend = 32'd100;
        Divisor  = 32'd7;
        run      = 1'b1;
        repeat (11) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_out", {Quotient, Remainder}, 64'h0);
        check("abort_flags", {ready, busy, div_by_zero}, 3'b000);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_quiet", {ready, busy}, 2'b00);
        run_op("u9_3", 1'b0, 32'd9, 32'd3);
        run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("s7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("smin", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("s_pos_neg", 1'b1, 32'd1000, 32'hFFFF_FFF9);
        for (int i = 0; i < 4; i++)
            run_op("rand", 1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31));
        @(negedge clk);
        a8   = 8'd200;
        b8   = 8'd13;
        run8 = 1'b1;
        e.q   = 32'(a8 / b8);
        e.r   = 32'(a8 % b8);
        e.z   = 1'b0;
        e.lat = 9;
        sb.push_back(e);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            a8 = 8'h55;
        end while (!rdy8 && n < 100);
        e = sb.pop_front();
        check("w8_lat", n, e.lat);
        check("w8_q", q8, e.q);
        check("w8_r", r8, e.r);
        check("w8_dbz", dbz8, e.z);
        repeat (4) @(negedge clk);
        check("w8_no_restart", {rdy8, busy8}, 2'b10);
        check("w8_hold_q", q8, e.q);
        run8 = 1'b0;
        @(negedge clk);
        check("w8_idle", rdy8, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end
endmodule
